// File: rtl/iomem_stream_pkg.sv
// Shared register-map constants for the iomem stream bridge.
// Offsets are word indices taken from iomem_addr[3:2].
package iomem_stream_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_FULL      = 16;
  localparam int unsigned ST_TX_EMPTY     = 17;
  localparam int unsigned ST_RX_FULL      = 18;
  localparam int unsigned ST_RX_EMPTY     = 19;
  localparam int unsigned ST_TX_OVF       = 20;
  localparam int unsigned ST_RX_UNF       = 21;

  localparam int unsigned CTRL_RX_IRQ_EN  = 0;
  localparam int unsigned CTRL_TX_IRQ_EN  = 1;
  localparam int unsigned CTRL_FLUSH_TX   = 2;
  localparam int unsigned CTRL_FLUSH_RX   = 3;
  localparam int unsigned CTRL_CLR_STICKY = 4;

endpackage

// File: rtl/iomem_stream_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with count and flush.
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;
  assign dout      = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage is not reset; dout is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (resetn && !flush && w_push_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

endmodule

// File: rtl/iomem_stream_fifo.sv
// iomem-bus stream bridge: CPU-fed TX FIFO to a master stream, slave stream into
// an RX FIFO popped by CPU reads, plus STATUS/CTRL registers and a level irq.
module iomem_stream_fifo
  import iomem_stream_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h04,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_irq;
  logic          r_rx_irq_en;
  logic          r_tx_irq_en;
  logic          r_tx_ovf;
  logic          r_rx_unf;

  logic          w_access;
  logic [1:0]    w_off;
  logic          w_rd;
  logic          w_wr;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_rx_pop_req;
  logic          w_ctrl_wr;
  logic          w_flush_tx;
  logic          w_flush_rx;
  logic          w_clr_sticky;
  logic          w_tx_ovf_set;
  logic          w_rx_unf_set;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_tx_count;
  logic [CW-1:0] w_rx_count;
  logic [31:0]   w_tx_dout;
  logic [31:0]   w_rx_dout;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // r_ready gates decode so a held request is serviced exactly once.
  assign w_access = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign w_off    = iomem_addr[3:2];
  assign w_rd     = w_access && (iomem_wstrb == 4'h0);
  assign w_wr     = w_access && (iomem_wstrb != 4'h0);

  assign w_tx_push    = w_wr && (w_off == OFF_DATA) && (iomem_wstrb == 4'hF);
  assign w_rx_pop_req = w_rd && (w_off == OFF_DATA);
  assign w_rx_pop     = w_rx_pop_req && !w_rx_empty;
  assign w_rx_unf_set = w_rx_pop_req && w_rx_empty;

  assign w_ctrl_wr    = w_wr && (w_off == OFF_CTRL) && iomem_wstrb[0];
  assign w_flush_tx   = w_ctrl_wr && iomem_wdata[CTRL_FLUSH_TX];
  assign w_flush_rx   = w_ctrl_wr && iomem_wdata[CTRL_FLUSH_RX];
  assign w_clr_sticky = w_ctrl_wr && iomem_wdata[CTRL_CLR_STICKY];

  assign m_valid      = !w_tx_empty;
  assign m_data       = w_tx_dout;
  assign w_tx_pop     = m_valid && m_ready;
  assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;

  assign s_ready   = resetn && !w_rx_full;
  assign w_rx_push = s_valid && s_ready;

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

  assign w_unused = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:5]};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_tx_push),
    .pop    (w_tx_pop),
    .flush  (w_flush_tx),
    .din    (iomem_wdata),
    .dout   (w_tx_dout),
    .full   (w_tx_full),
    .empty  (w_tx_empty),
    .count  (w_tx_count)
  );

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_rx_push),
    .pop    (w_rx_pop),
    .flush  (w_flush_rx),
    .din    (s_data),
    .dout   (w_rx_dout),
    .full   (w_rx_full),
    .empty  (w_rx_empty),
    .count  (w_rx_count)
  );

  always_comb begin
    w_status                            = '0;
    w_status[CW-1:0]                    = w_tx_count;
    w_status[ST_RX_COUNT_LSB +: CW]     = w_rx_count;
    w_status[ST_TX_FULL]                = w_tx_full;
    w_status[ST_TX_EMPTY]               = w_tx_empty;
    w_status[ST_RX_FULL]                = w_rx_full;
    w_status[ST_RX_EMPTY]               = w_rx_empty;
    w_status[ST_TX_OVF]                 = r_tx_ovf;
    w_status[ST_RX_UNF]                 = r_rx_unf;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        OFF_DATA:   w_rdata = w_rx_dout;
        OFF_STATUS: w_rdata = w_status;
        OFF_CTRL: begin
          w_rdata[CTRL_RX_IRQ_EN] = r_rx_irq_en;
          w_rdata[CTRL_TX_IRQ_EN] = r_tx_irq_en;
        end
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_rx_unf    <= 1'b0;
    end else begin
      r_ready <= w_access;
      r_rdata <= w_access ? w_rdata : '0;
      r_irq   <= (r_rx_irq_en && !w_rx_empty) || (r_tx_irq_en && w_tx_empty);
      if (w_ctrl_wr) begin
        r_rx_irq_en <= iomem_wdata[CTRL_RX_IRQ_EN];
        r_tx_irq_en <= iomem_wdata[CTRL_TX_IRQ_EN];
      end
      // Set events take priority over a same-cycle clear.
      if (w_tx_ovf_set)      r_tx_ovf <= 1'b1;
      else if (w_clr_sticky) r_tx_ovf <= 1'b0;
      if (w_rx_unf_set)      r_rx_unf <= 1'b1;
      else if (w_clr_sticky) r_rx_unf <= 1'b0;
    end
  end

endmodule
